// File: rtl/sw_to_fw_cmd_dispatcher_pkg.sv
// Shared types and field/bit positions for the SW-to-FW command dispatcher.
package sw_fw_cmd_pkg;

  // Firmware op codes; C..F are reserved and rejected by the decoder.
  typedef enum logic [3:0] {
    OP_NOOP           = 4'h0,
    OP_W_RST_FW       = 4'h1,
    OP_W_CFG_STATIC_0 = 4'h2,
    OP_R_CFG_STATIC_0 = 4'h3,
    OP_W_CFG_ARRAY_0  = 4'h4,
    OP_R_CFG_ARRAY_0  = 4'h5,
    OP_W_CFG_ARRAY_1  = 4'h6,
    OP_R_CFG_ARRAY_1  = 4'h7,
    OP_R_DATA_ARRAY_0 = 4'h8,
    OP_R_DATA_ARRAY_1 = 4'h9,
    OP_R_STATUS_FW    = 4'hA,
    OP_W_EXEC_TEST_0  = 4'hB
  } op_code_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Command word fields
  localparam int DEV_HI  = 31;
  localparam int DEV_LO  = 28;
  localparam int OP_HI   = 27;
  localparam int OP_LO   = 24;
  localparam int BODY_HI = 23;
  localparam int BODY_LO = 0;

  // Status word (register 1) bit positions
  localparam int ST_BUSY      = 31;
  localparam int ST_TIMEOUT   = 30;
  localparam int ST_DECODE    = 29;
  localparam int ST_OVERRUN   = 28;
  localparam int ST_LASTOP_HI = 27;
  localparam int ST_LASTOP_LO = 24;

  // Command word viewed as a request struct
  typedef struct packed {
    logic [DEV_HI-DEV_LO:0]   dev;
    logic [OP_HI-OP_LO:0]     op;
    logic [BODY_HI-BODY_LO:0] body;
  } cmd_t;

  // One-hot 16-bit vector indexed by op code
  function automatic logic [15:0] op_onehot(input logic [3:0] op);
    return 16'd1 << op;
  endfunction

endpackage

// File: rtl/sw_to_fw_cmd_dispatcher_if.sv
// SW register bank + firmware channel bundle. master = SW/FW side, slave = dispatcher.
interface sw_to_fw_cmd_dispatcher_if #(
  parameter int NUM_FW = 4
);
  logic [31:0]              sw_write32_0;
  logic                     sw_write_valid;
  logic [31:0]              sw_read32_0;
  logic [31:0]              sw_read32_1;
  logic [NUM_FW-1:0]        fw_dev_id_enable;
  logic [15:0]              fw_op_code_strobe;
  logic [15:0]              fw_op_code_level;
  logic [23:0]              fw_body24;
  logic [NUM_FW-1:0]        fw_done;
  logic [NUM_FW-1:0][31:0]  fw_read_data32;
  logic [NUM_FW-1:0][31:0]  fw_read_status32;

  modport master (
    output sw_write32_0, sw_write_valid, fw_done, fw_read_data32, fw_read_status32,
    input  sw_read32_0, sw_read32_1, fw_dev_id_enable, fw_op_code_strobe,
           fw_op_code_level, fw_body24
  );

  modport slave (
    input  sw_write32_0, sw_write_valid, fw_done, fw_read_data32, fw_read_status32,
    output sw_read32_0, sw_read32_1, fw_dev_id_enable, fw_op_code_strobe,
           fw_op_code_level, fw_body24
  );
endinterface

// File: rtl/sw_cmd_field_decode.sv
// Combinational device-ID / op-code decode of a raw command word.
module sw_cmd_field_decode
  import sw_fw_cmd_pkg::*;
#(
  parameter int NUM_FW    = 4,
  parameter int ID_ONEHOT = 1
) (
  input  logic [3:0]        dev,
  input  logic [3:0]        op,
  output logic [NUM_FW-1:0] sel,
  output logic              dev_valid,
  output logic              op_valid
);

  // Per-channel match: a valid ID hits exactly one channel, so an invalid
  // ID (zero, multi-bit, out of range) simply leaves sel all zero.
  for (genvar i = 0; i < NUM_FW; i++) begin : g_ch
    if (ID_ONEHOT != 0 && i < 4) begin : g_oh
      assign sel[i] = (dev == 4'(1 << i));
    end else if (ID_ONEHOT != 0) begin : g_oh_none
      assign sel[i] = 1'b0;
    end else begin : g_bin
      assign sel[i] = (dev == 4'(i + 1));
    end
  end

  assign dev_valid = |sel;
  assign op_valid  = (op <= 4'(OP_W_EXEC_TEST_0));

endmodule

// File: rtl/sw_to_fw_cmd_dispatcher.sv
// Registered SW-to-FW command dispatcher: latch, decode, issue, track completion.
module sw_to_fw_cmd_dispatcher
  import sw_fw_cmd_pkg::*;
#(
  parameter int NUM_FW         = 4,
  parameter int ID_ONEHOT      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sw_to_fw_cmd_dispatcher_if.slave bus
);

  // A disabled timeout still needs a 1-bit counter to keep widths legal.
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  cmd_t              cmd;
  logic [NUM_FW-1:0] dec_sel;
  logic              dev_valid, op_valid;

  state_e            state_q, state_d;
  logic [NUM_FW-1:0] sel_q;
  logic [3:0]        op_q, last_op_q;
  logic [23:0]       body_q;
  logic              timeout_err_q, decode_err_q, overrun_err_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [23:0]       rd_stat_q, rd_stat_d;
  logic              unused_stat_hi;

  logic              idle_wr, accept_go, accept_noop, reject;
  logic              done_sel, timeout_hit, busy;
  logic [15:0]       strobe, level;

  assign cmd = cmd_t'(bus.sw_write32_0);

  sw_cmd_field_decode #(
    .NUM_FW    (NUM_FW),
    .ID_ONEHOT (ID_ONEHOT)
  ) u_dec (
    .dev       (cmd.dev),
    .op        (cmd.op),
    .sel       (dec_sel),
    .dev_valid (dev_valid),
    .op_valid  (op_valid)
  );

  // Command classification; only meaningful while idle.
  assign idle_wr     = (state_q == S_IDLE) && bus.sw_write_valid;
  assign reject      = idle_wr && !(dev_valid && op_valid);
  assign accept_noop = idle_wr && dev_valid && op_valid && (cmd.op == 4'(OP_NOOP));
  assign accept_go   = idle_wr && dev_valid && op_valid && (cmd.op != 4'(OP_NOOP));
  assign done_sel    = |(bus.fw_done & sel_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: done wins over timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_go) state_d = S_ISSUE;
      S_ISSUE: state_d = done_sel ? S_IDLE : S_WAIT;
      S_WAIT:  if (done_sel || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobe only in ISSUE, level across ISSUE and WAIT
  always_comb begin
    busy   = (state_q != S_IDLE);
    strobe = '0;
    level  = '0;
    if (state_q == S_ISSUE) strobe = op_onehot(op_q);
    if (busy)               level  = op_onehot(op_q);
  end

  // Command latches; a rejected command drops the channel select so that
  // nothing stays enabled and FW-sourced read fields return to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      op_q      <= '0;
      body_q    <= '0;
      last_op_q <= '0;
    end else begin
      if (accept_go) begin
        sel_q  <= dec_sel;
        op_q   <= cmd.op;
        body_q <= cmd.body;
      end else if (reject) begin
        sel_q  <= '0;
      end
      if (idle_wr) last_op_q <= cmd.op;
    end
  end

  // Sticky error flags, cleared only by a command that is not an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
      decode_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (accept_go || accept_noop) begin
        timeout_err_q <= 1'b0;
        decode_err_q  <= 1'b0;
        overrun_err_q <= 1'b0;
      end
      if (reject)                             decode_err_q  <= 1'b1;
      if (busy && bus.sw_write_valid)         overrun_err_q <= 1'b1;
      if (state_q == S_WAIT && !done_sel && timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  // WAIT cycle counter: cleared in ISSUE, saturating in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  cnt_q <= '0;
    else if (state_q == S_ISSUE)                 cnt_q <= '0;
    else if (state_q == S_WAIT && cnt_q != '1)   cnt_q <= cnt_q + CW'(1);
  end

  // Read mux over the latched one-hot select; zero when nothing is selected
  always_comb begin
    rd_data_d      = '0;
    rd_stat_d      = '0;
    unused_stat_hi = 1'b0;
    for (int i = 0; i < NUM_FW; i++) begin
      rd_data_d      = rd_data_d | (bus.fw_read_data32[i] & {32{sel_q[i]}});
      rd_stat_d      = rd_stat_d | (bus.fw_read_status32[i][23:0] & {24{sel_q[i]}});
      unused_stat_hi = unused_stat_hi ^ (^bus.fw_read_status32[i][31:24]);
    end
  end

  // Registered read-back of the selected channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_stat_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_stat_q <= rd_stat_d;
    end
  end

  assign bus.sw_read32_0       = rd_data_q;
  assign bus.sw_read32_1       = {busy, timeout_err_q, decode_err_q, overrun_err_q,
                                  last_op_q, rd_stat_q};
  assign bus.fw_dev_id_enable  = sel_q;
  assign bus.fw_op_code_strobe = strobe;
  assign bus.fw_op_code_level  = level;
  assign bus.fw_body24         = body_q;

endmodule
